// File: rtl/mux_4x1_rr.sv
// Clocked 4-to-1 valid/ready stream merger with round-robin arbitration.
// The output word is registered and tagged with the index of its source channel.
module mux_4x1_rr #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [3:0]         in_valid,
   input  logic [4*WIDTH-1:0] in_data,
   output logic [3:0]         in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [1:0]         out_sel,
   input  logic               out_ready
);

   logic [1:0]       r_ptr;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic [1:0]       r_out_sel;

   logic             w_load;
   logic             w_grant_valid;
   logic [1:0]       w_grant_idx;
   logic [1:0]       w_scan_idx;
   logic             w_xfer;

   assign w_load = !r_out_valid || out_ready;

   // Scan from the priority pointer upward; the first requester wins.
   always_comb begin
      w_grant_valid = 1'b0;
      w_grant_idx   = 2'd0;
      w_scan_idx    = 2'd0;
      for (int k = 0; k < 4; k++) begin
         w_scan_idx = r_ptr + 2'(k);
         if (!w_grant_valid && in_valid[w_scan_idx]) begin
            w_grant_valid = 1'b1;
            w_grant_idx   = w_scan_idx;
         end
      end
   end

   assign w_xfer = rst_n && w_load && w_grant_valid;

   always_comb begin
      in_ready = 4'b0000;
      if (w_xfer) begin
         in_ready[w_grant_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr       <= 2'd0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sel   <= 2'd0;
      end else if (w_load) begin
         if (w_grant_valid) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data[w_grant_idx*WIDTH +: WIDTH];
            r_out_sel   <= w_grant_idx;
            r_ptr       <= w_grant_idx + 2'd1;
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sel   = r_out_sel;

endmodule
